// File: rtl/prefetch_pkg.sv
// Shared prefetcher definitions: default table geometry and the per-entry record.
package prefetch_pkg;
  localparam int LOG_VEC_SIZE_DEF = 3;
  localparam int TAG_SIZE_DEF     = 64;

  // One tag-table entry at the default geometry; age 0 is most recently used.
  typedef struct packed {
    logic [TAG_SIZE_DEF-1:0]     tag;
    logic                        valid;
    logic [LOG_VEC_SIZE_DEF-1:0] age;
  } entry_t;
endpackage

// File: rtl/tag_match.sv
// Combinational associative search: hit plus lowest matching index over valid entries.
module tag_match #(
  parameter int LOG_VEC_SIZE = 3,
  parameter int TAG_SIZE     = 64
) (
  input  logic [TAG_SIZE-1:0]                       tag,
  input  logic [(1<<LOG_VEC_SIZE)-1:0]              valid,
  input  logic [(1<<LOG_VEC_SIZE)-1:0][TAG_SIZE-1:0] tags,
  output logic                                      hit,
  output logic [LOG_VEC_SIZE-1:0]                   idx
);
  localparam int VEC_SIZE = 1 << LOG_VEC_SIZE;

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = VEC_SIZE - 1; i >= 0; i--) begin
      if (valid[i] && tags[i] == tag) begin
        hit = 1'b1;
        idx = LOG_VEC_SIZE'(i);
      end
    end
  end
endmodule

// File: rtl/tag_table_lru.sv
// Fully associative stream-tag table with true-LRU replacement for the prefetcher.
module tag_table_lru
  import prefetch_pkg::*;
#(
  parameter int LOG_VEC_SIZE = LOG_VEC_SIZE_DEF,
  parameter int TAG_SIZE     = TAG_SIZE_DEF
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    lookupValid,
  input  logic [TAG_SIZE-1:0]     lookupTag,
  output logic                    lookupRespValid,
  output logic                    lookupHit,
  output logic [LOG_VEC_SIZE-1:0] lookupIdx,
  input  logic                    insertValid,
  input  logic [TAG_SIZE-1:0]     insertTag,
  output logic                    insertDone,
  output logic [LOG_VEC_SIZE-1:0] insertIdx,
  output logic                    evictValid,
  output logic [TAG_SIZE-1:0]     evictTag,
  input  logic                    invalValid,
  input  logic [LOG_VEC_SIZE-1:0] invalIdx,
  output logic [LOG_VEC_SIZE:0]   count,
  output logic                    full
);
  localparam int VEC_SIZE = 1 << LOG_VEC_SIZE;

  typedef struct packed {
    logic [TAG_SIZE-1:0]     tag;
    logic                    valid;
    logic [LOG_VEC_SIZE-1:0] age;
  } ent_t;

  ent_t ent_q [VEC_SIZE];
  ent_t ent_d [VEC_SIZE];

  logic                    resp_vld_q, resp_vld_d, resp_hit_q, resp_hit_d;
  logic [LOG_VEC_SIZE-1:0] resp_idx_q, resp_idx_d, ins_idx_q, ins_idx_d;
  logic                    ins_done_q, ins_done_d, evict_vld_q, evict_vld_d;
  logic [TAG_SIZE-1:0]     evict_tag_q, evict_tag_d;
  logic [LOG_VEC_SIZE:0]   count_q, count_d;
  logic                    full_q, full_d;

  logic [VEC_SIZE-1:0]               valid_cur, valid_post;
  logic [VEC_SIZE-1:0][TAG_SIZE-1:0] tags_cur;
  logic                    lk_hit, in_hit, free_any, evict, touch_en;
  logic [LOG_VEC_SIZE-1:0] lk_idx, in_idx, free_idx, lru_idx, ins_idx, touch_idx;

  // Flatten entry state for the matchers; insert dedup sees the post-invalidate view.
  always_comb begin
    valid_cur = '0;
    tags_cur  = '0;
    for (int i = 0; i < VEC_SIZE; i++) begin
      valid_cur[i] = ent_q[i].valid;
      tags_cur[i]  = ent_q[i].tag;
    end
    valid_post = valid_cur;
    if (invalValid) valid_post[invalIdx] = 1'b0;
  end

  tag_match #(.LOG_VEC_SIZE(LOG_VEC_SIZE), .TAG_SIZE(TAG_SIZE)) u_lookup_match (
    .tag(lookupTag), .valid(valid_cur), .tags(tags_cur), .hit(lk_hit), .idx(lk_idx)
  );

  tag_match #(.LOG_VEC_SIZE(LOG_VEC_SIZE), .TAG_SIZE(TAG_SIZE)) u_insert_match (
    .tag(insertTag), .valid(valid_post), .tags(tags_cur), .hit(in_hit), .idx(in_idx)
  );

  // Victim choice: existing copy, else lowest free slot, else the LRU entry.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    lru_idx  = '0;
    for (int i = VEC_SIZE - 1; i >= 0; i--) begin
      if (!valid_post[i]) begin
        free_any = 1'b1;
        free_idx = LOG_VEC_SIZE'(i);
      end
      if (ent_q[i].age == LOG_VEC_SIZE'(VEC_SIZE - 1)) lru_idx = LOG_VEC_SIZE'(i);
    end
    ins_idx   = in_hit ? in_idx : (free_any ? free_idx : lru_idx);
    evict     = insertValid && !in_hit && !free_any;
    touch_en  = insertValid || (lookupValid && lk_hit);
    touch_idx = insertValid ? ins_idx : lk_idx;
  end

  // Next entry state: invalidate, write the insert, then apply the single LRU touch.
  always_comb begin
    count_d = '0;
    for (int j = 0; j < VEC_SIZE; j++) begin
      ent_d[j]       = ent_q[j];
      ent_d[j].valid = valid_post[j];
      if (insertValid && ins_idx == LOG_VEC_SIZE'(j)) begin
        ent_d[j].valid = 1'b1;
        ent_d[j].tag   = insertTag;
      end
      if (touch_en) begin
        if (touch_idx == LOG_VEC_SIZE'(j))               ent_d[j].age = '0;
        else if (ent_q[j].age < ent_q[touch_idx].age) ent_d[j].age = ent_q[j].age + 1'b1;
      end
      count_d = count_d + (LOG_VEC_SIZE+1)'(ent_d[j].valid);
    end
    full_d = (count_d == (LOG_VEC_SIZE+1)'(VEC_SIZE));
  end

  // Response pulses; lookup answers from the pre-update state.
  always_comb begin
    resp_vld_d  = lookupValid;
    resp_hit_d  = lookupValid && lk_hit;
    resp_idx_d  = (lookupValid && lk_hit) ? lk_idx : '0;
    ins_done_d  = insertValid;
    ins_idx_d   = insertValid ? ins_idx : '0;
    evict_vld_d = evict;
    evict_tag_d = evict ? ent_q[lru_idx].tag : '0;
  end

  // State and output registers; reset clears the table and restores ages to index order.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < VEC_SIZE; i++) begin
        ent_q[i].tag   <= '0;
        ent_q[i].valid <= 1'b0;
        ent_q[i].age   <= LOG_VEC_SIZE'(i);
      end
      resp_vld_q  <= 1'b0;
      resp_hit_q  <= 1'b0;
      resp_idx_q  <= '0;
      ins_done_q  <= 1'b0;
      ins_idx_q   <= '0;
      evict_vld_q <= 1'b0;
      evict_tag_q <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
    end else begin
      for (int i = 0; i < VEC_SIZE; i++) ent_q[i] <= ent_d[i];
      resp_vld_q  <= resp_vld_d;
      resp_hit_q  <= resp_hit_d;
      resp_idx_q  <= resp_idx_d;
      ins_done_q  <= ins_done_d;
      ins_idx_q   <= ins_idx_d;
      evict_vld_q <= evict_vld_d;
      evict_tag_q <= evict_tag_d;
      count_q     <= count_d;
      full_q      <= full_d;
    end
  end

  assign lookupRespValid = resp_vld_q;
  assign lookupHit       = resp_hit_q;
  assign lookupIdx       = resp_idx_q;
  assign insertDone      = ins_done_q;
  assign insertIdx       = ins_idx_q;
  assign evictValid      = evict_vld_q;
  assign evictTag        = evict_tag_q;
  assign count           = count_q;
  assign full            = full_q;
endmodule
